// File: rtl/dmem_bridge.sv
// dmem_bridge: bridges the core's single-cycle data-memory port onto a
// valid/ready data bus. Stalls the core for the duration of each access,
// returns right-aligned load data, and flags misaligned accesses and read
// timeouts.
//
// Ports:
//   clk, reset                 clock and asynchronous active-low reset
//   cpu_req/we/addr/wdata/size core request (held stable while stalled)
//   cpu_stall                  combinational stall back to the core
//   cpu_rdata, cpu_err         load result and error flag, valid in DONE
//   bus_valid/ready            request handshake
//   bus_we/addr/wdata/wstrb    request payload (word-aligned, lane-shifted)
//   bus_rvalid/rdata           read response
module dmem_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [1:0]  cpu_size,
  output logic        cpu_stall,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       off_q, off_d;
  logic [31:0]      rdata_d, addr_d, wdata_d;
  logic             err_d, valid_d, we_d;
  logic [3:0]       wstrb_d;

  logic             misalign_c;
  logic [3:0]       strb_c;
  logic [CNT_W-1:0] cnt_inc_c;

  // Half needs addr[0]=0; word (and the 11 encoding) needs addr[1:0]=0.
  assign misalign_c = ((cpu_size == 2'b01) && cpu_addr[0]) ||
                      (cpu_size[1] && (cpu_addr[1:0] != 2'b00));

  // Byte-lane strobes for the current request.
  always_comb begin
    strb_c = 4'b1111;
    case (cpu_size)
      2'b00:   strb_c = 4'b0001 << cpu_addr[1:0];
      2'b01:   strb_c = 4'b0011 << cpu_addr[1:0];
      default: strb_c = 4'b1111;
    endcase
  end

  assign cnt_inc_c = cnt_q + CNT_W'(1);

  // Stall asserts in the same cycle the request appears; DONE releases it.
  assign cpu_stall = cpu_req & (state_q != DONE);

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    rdata_d = cpu_rdata;
    err_d   = cpu_err;
    valid_d = bus_valid;
    we_d    = bus_we;
    addr_d  = bus_addr;
    wdata_d = bus_wdata;
    wstrb_d = bus_wstrb;

    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          if (misalign_c) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            addr_d  = {cpu_addr[31:2], 2'b00};
            we_d    = cpu_we;
            wdata_d = cpu_wdata << {cpu_addr[1:0], 3'b000};
            wstrb_d = strb_c;
            off_d   = cpu_addr[1:0];
            valid_d = 1'b1;
            state_d = REQ;
          end
        end
      end

      REQ: begin
        if (bus_ready) begin
          valid_d = 1'b0;
          cnt_d   = '0;
          if (bus_we) begin
            err_d   = 1'b0;
            state_d = DONE;
          end else begin
            state_d = WAIT_R;
          end
        end
      end

      WAIT_R: begin
        if (bus_rvalid) begin
          rdata_d = bus_rdata >> {off_q, 3'b000};
          err_d   = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_inc_c;
          // Abort once TIMEOUT rvalid-less cycles have elapsed; rdata is kept.
          if (cnt_inc_c == CNT_W'(TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        // Request still visible here belongs to the retiring instruction.
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      off_q     <= 2'b00;
      cpu_rdata <= 32'h0;
      cpu_err   <= 1'b0;
      bus_valid <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
      bus_wstrb <= 4'b0000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      off_q     <= off_d;
      cpu_rdata <= rdata_d;
      cpu_err   <= err_d;
      bus_valid <= valid_d;
      bus_we    <= we_d;
      bus_addr  <= addr_d;
      bus_wdata <= wdata_d;
      bus_wstrb <= wstrb_d;
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: self-checking bench for dmem_bridge. Each scenario task
// drives core requests and a simple bus responder, pushes the expected core
// result into a scoreboard and compares it when DONE is observed.
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [1:0]  cpu_size;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  logic        bus_valid, bus_ready, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_rdata = 32'h0;

  typedef struct {
    logic        done;
    int          cycles;
    int          stalls;
    int          vcycles;
    logic        unstable;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        err;
  } obs_t;

  always #5 clk = ~clk;

  dmem_bridge #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_size  (cpu_size),
    .cpu_stall (cpu_stall),
    .cpu_rdata (cpu_rdata),
    .cpu_err   (cpu_err),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_wstrb (bus_wstrb),
    .bus_rvalid(bus_rvalid),
    .bus_rdata (bus_rdata)
  );

  // Runs one core access with a bus responder: ready after rdy_wait stalled
  // valid cycles, rvalid after rv_wait WAIT_R cycles (if rv_en). Observes only.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] size, input int rdy_wait, input int rv_wait,
                         input logic rv_en, input logic [31:0] rd, output obs_t o);
    int   hcnt;
    logic hs;
    o = '{default: 0};
    hcnt = 0;
    hs = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_size = size;
    bus_rdata = rd; bus_ready = 1'b0; bus_rvalid = 1'b0;
    for (int c = 0; c < 64; c++) begin
      #1;
      if (!cpu_stall) begin
        o.done = 1'b1; o.cycles = c + 1; o.rdata = cpu_rdata; o.err = cpu_err;
        break;
      end
      o.stalls++;
      if (bus_valid) begin
        o.vcycles++;
        if (o.vcycles == 1) begin
          o.we = bus_we; o.addr = bus_addr; o.wdata = bus_wdata; o.wstrb = bus_wstrb;
        end else if (o.we !== bus_we || o.addr !== bus_addr || o.wdata !== bus_wdata ||
                     o.wstrb !== bus_wstrb) begin
          o.unstable = 1'b1;
        end
        bus_ready = (o.vcycles > rdy_wait);
        if (bus_ready) hs = 1'b1;
      end else begin
        bus_ready = 1'b0;
        if (hs) begin
          hcnt++;
          bus_rvalid = rv_en && (hcnt > rv_wait);
        end
      end
      @(negedge clk);
    end
    cpu_req = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    checks++;
    if ({bus_valid, bus_we, cpu_err, cpu_stall} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=0000", {bus_valid, bus_we, cpu_err, cpu_stall});
    end
    checks++;
    if ({bus_addr, bus_wdata, cpu_rdata, bus_wstrb} !== 100'h0) begin
      errors++;
      $display("FAIL reset_data addr=%h wdata=%h rdata=%h wstrb=%b exp all zero",
               bus_addr, bus_wdata, cpu_rdata, bus_wstrb);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_store();
    logic [31:0] a[3]  = '{32'h100, 32'h203, 32'h0A2};
    logic [31:0] d[3]  = '{32'hDEADBEEF, 32'h000000AB, 32'h00005678};
    logic [1:0]  s[3]  = '{2'b10, 2'b00, 2'b01};
    logic [31:0] ea[3] = '{32'h100, 32'h200, 32'h0A0};
    logic [31:0] ed[3] = '{32'hDEADBEEF, 32'hAB000000, 32'h56780000};
    logic [3:0]  es[3] = '{4'b1111, 4'b1000, 4'b1100};
    obs_t o;
    exp_t ex;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{rdata: model_rdata, err: 1'b0});
      run_txn(1'b1, a[i], d[i], s[i], 0, 0, 1'b0, 32'h0, o);
      ex = exp_q.pop_front();
      checks++;
      if (o.done !== 1'b1 || o.cycles != 3 || o.stalls != 2 || o.vcycles != 1) begin
        errors++;
        $display("FAIL store[%0d]_timing done=%b cycles=%0d stalls=%0d valid=%0d exp 1/3/2/1",
                 i, o.done, o.cycles, o.stalls, o.vcycles);
      end
      checks++;
      if (o.we !== 1'b1 || o.addr !== ea[i]) begin
        errors++;
        $display("FAIL store[%0d]_addr we=%b addr=%h exp we=1 addr=%h", i, o.we, o.addr, ea[i]);
      end
      checks++;
      if (o.wdata !== ed[i]) begin
        errors++;
        $display("FAIL store[%0d]_wdata got=%h exp=%h", i, o.wdata, ed[i]);
      end
      checks++;
      if (o.wstrb !== es[i]) begin
        errors++;
        $display("FAIL store[%0d]_wstrb got=%b exp=%b", i, o.wstrb, es[i]);
      end
      checks++;
      if (o.err !== ex.err || o.rdata !== ex.rdata) begin
        errors++;
        $display("FAIL store[%0d]_result err=%b rdata=%h exp err=%b rdata=%h",
                 i, o.err, o.rdata, ex.err, ex.rdata);
      end
    end
  endtask

  task automatic test_load();
    logic [31:0] a[3]  = '{32'h302, 32'h501, 32'h600};
    logic [1:0]  s[3]  = '{2'b01, 2'b00, 2'b11};
    logic [31:0] rd[3] = '{32'h1234ABCD, 32'hA1B2C3D4, 32'hCAFEF00D};
    int          rw[3] = '{3, 0, 1};
    int          vw[3] = '{2, 0, 0};
    logic [31:0] er[3] = '{32'h00001234, 32'h00A1B2C3, 32'hCAFEF00D};
    logic [31:0] ea[3] = '{32'h300, 32'h500, 32'h600};
    logic [3:0]  es[3] = '{4'b1100, 4'b0010, 4'b1111};
    int          st[3] = '{8, 3, 4};
    obs_t o;
    exp_t ex;
    for (int i = 0; i < 3; i++) begin
      model_rdata = er[i];
      exp_q.push_back('{rdata: model_rdata, err: 1'b0});
      run_txn(1'b0, a[i], 32'h0, s[i], rw[i], vw[i], 1'b1, rd[i], o);
      ex = exp_q.pop_front();
      checks++;
      if (o.done !== 1'b1 || o.stalls != st[i] || o.vcycles != rw[i] + 1 || o.unstable !== 1'b0) begin
        errors++;
        $display("FAIL load[%0d]_timing done=%b stalls=%0d valid=%0d unstable=%b exp 1/%0d/%0d/0",
                 i, o.done, o.stalls, o.vcycles, o.unstable, st[i], rw[i] + 1);
      end
      checks++;
      if (o.we !== 1'b0 || o.addr !== ea[i] || o.wstrb !== es[i]) begin
        errors++;
        $display("FAIL load[%0d]_bus we=%b addr=%h wstrb=%b exp we=0 addr=%h wstrb=%b",
                 i, o.we, o.addr, o.wstrb, ea[i], es[i]);
      end
      checks++;
      if (o.err !== ex.err || o.rdata !== ex.rdata) begin
        errors++;
        $display("FAIL load[%0d]_result err=%b rdata=%h exp err=%b rdata=%h",
                 i, o.err, o.rdata, ex.err, ex.rdata);
      end
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] a[3] = '{32'h401, 32'h403, 32'h602};
    logic [1:0]  s[3] = '{2'b10, 2'b01, 2'b11};
    logic        w[3] = '{1'b0, 1'b0, 1'b1};
    obs_t o;
    exp_t ex;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{rdata: model_rdata, err: 1'b1});
      run_txn(w[i], a[i], 32'h55555555, s[i], 0, 0, 1'b1, 32'h99999999, o);
      ex = exp_q.pop_front();
      checks++;
      if (o.done !== 1'b1 || o.cycles != 2 || o.stalls != 1 || o.vcycles != 0) begin
        errors++;
        $display("FAIL misalign[%0d]_timing done=%b cycles=%0d stalls=%0d valid=%0d exp 1/2/1/0",
                 i, o.done, o.cycles, o.stalls, o.vcycles);
      end
      checks++;
      if (o.err !== ex.err || o.rdata !== ex.rdata) begin
        errors++;
        $display("FAIL misalign[%0d]_result err=%b rdata=%h exp err=%b rdata=%h",
                 i, o.err, o.rdata, ex.err, ex.rdata);
      end
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    exp_t ex;
    exp_q.push_back('{rdata: model_rdata, err: 1'b1});
    run_txn(1'b0, 32'h700, 32'h0, 2'b10, 0, 0, 1'b0, 32'h0, o);
    ex = exp_q.pop_front();
    checks++;
    if (o.done !== 1'b1 || o.cycles != 7 || o.stalls != 6) begin
      errors++;
      $display("FAIL timeout_timing done=%b cycles=%0d stalls=%0d exp 1/7/6",
               o.done, o.cycles, o.stalls);
    end
    checks++;
    if (o.err !== ex.err || o.rdata !== ex.rdata) begin
      errors++;
      $display("FAIL timeout_result err=%b rdata=%h exp err=%b rdata=%h",
               o.err, o.rdata, ex.err, ex.rdata);
    end
    // Late response after the abort must not disturb anything.
    @(negedge clk);
    bus_rdata = 32'hFFFF0000;
    bus_rvalid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (cpu_rdata !== model_rdata || bus_valid !== 1'b0 || cpu_stall !== 1'b0) begin
      errors++;
      $display("FAIL late_rvalid rdata=%h valid=%b stall=%b exp rdata=%h valid=0 stall=0",
               cpu_rdata, bus_valid, cpu_stall, model_rdata);
    end
    bus_rvalid = 1'b0;
    model_rdata = 32'h11223344;
    exp_q.push_back('{rdata: model_rdata, err: 1'b0});
    run_txn(1'b0, 32'h704, 32'h0, 2'b10, 0, 0, 1'b1, 32'h11223344, o);
    ex = exp_q.pop_front();
    checks++;
    if (o.stalls != 3 || o.err !== ex.err || o.rdata !== ex.rdata) begin
      errors++;
      $display("FAIL after_timeout stalls=%0d err=%b rdata=%h exp 3 err=%b rdata=%h",
               o.stalls, o.err, o.rdata, ex.err, ex.rdata);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    exp_t ex;
    for (int ph = 0; ph < 2; ph++) begin
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h800; cpu_size = 2'b10;
      bus_ready = (ph == 1); bus_rvalid = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (bus_valid !== 1'b1) begin
        errors++;
        $display("FAIL rstmid[%0d]_req valid=%b exp=1", ph, bus_valid);
      end
      if (ph == 1) begin
        @(negedge clk);
        bus_ready = 1'b0;
        #1;
        checks++;
        if (bus_valid !== 1'b0 || cpu_stall !== 1'b1) begin
          errors++;
          $display("FAIL rstmid_wait valid=%b stall=%b exp valid=0 stall=1", bus_valid, cpu_stall);
        end
      end
      #1;
      reset = 1'b0;
      #1;
      checks++;
      if ({bus_valid, bus_we, cpu_err} !== 3'b000 || bus_addr !== 32'h0 || cpu_rdata !== 32'h0) begin
        errors++;
        $display("FAIL rstmid[%0d]_async valid=%b we=%b err=%b addr=%h rdata=%h exp all zero",
                 ph, bus_valid, bus_we, cpu_err, bus_addr, cpu_rdata);
      end
      @(negedge clk);
      cpu_req = 1'b0;
      reset = 1'b1;
      model_rdata = 32'h0;
      if (ph == 1) model_rdata = 32'h0BADF00D;
      exp_q.push_back('{rdata: model_rdata, err: 1'b0});
      run_txn(ph == 0, 32'h900 + 32'(ph * 4), 32'h13579BDF, 2'b10, 0, 0, 1'b1, 32'h0BADF00D, o);
      ex = exp_q.pop_front();
      checks++;
      if (o.done !== 1'b1 || o.stalls != 2 + ph || o.vcycles != 1 ||
          o.addr !== 32'h900 + 32'(ph * 4)) begin
        errors++;
        $display("FAIL rstmid[%0d]_fresh done=%b stalls=%0d valid=%0d addr=%h exp 1/%0d/1/%h",
                 ph, o.done, o.stalls, o.vcycles, o.addr, 2 + ph, 32'h900 + 32'(ph * 4));
      end
      checks++;
      if (o.err !== ex.err || o.rdata !== ex.rdata) begin
        errors++;
        $display("FAIL rstmid[%0d]_result err=%b rdata=%h exp err=%b rdata=%h",
                 ph, o.err, o.rdata, ex.err, ex.rdata);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_size = 2'b00;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    test_reset();
    test_store();
    test_load();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
